// File: rtl/load_store_unit_pkg.sv
// Shared encodings for the load/store unit: funct3 access sizes, FSM states
// and the default memory-acknowledge timeout.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned TIMEOUT_DEFAULT = 255;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_DONE
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store data replication and byte strobes, plus
// load byte/half extraction with sign or zero extension.
module lsu_align
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic [31:0] load_data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    wdata = store_data;
    wstrb = '0;
    case (funct3)
      F3_B: begin
        wdata = {4{store_data[7:0]}};
        wstrb = 4'b0001 << addr_lo;
      end
      F3_H: begin
        wdata = {2{store_data[15:0]}};
        wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      F3_W:    wstrb = '1;
      default: wstrb = '0;
    endcase
  end

  // Misaligned halves/words fall back to their naturally aligned lane.
  always_comb begin
    byte_sel  = load_word[{addr_lo, 3'b000} +: 8];
    half_sel  = addr_lo[1] ? load_word[31:16] : load_word[15:0];
    load_data = load_word;
    case (funct3)
      F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   load_data = {24'h000000, byte_sel};
      F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
      F3_HU:   load_data = {16'h0000, half_sel};
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit with ack timeout. Define
// LSU_MISALIGN_TRAP_EN to reject misaligned halfword/word accesses.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req_Valid_i,
  output logic        Req_Ready_o,
  input  logic        Mem_Write_i,
  input  logic [2:0]  Funct3_i,
  input  logic [31:0] Address_i,
  input  logic [31:0] Store_Data_i,
  output logic [31:0] Load_Data_o,
  output logic        Done_o,
  output logic        Error_o,
  output logic        Stall_o,
  output logic        Mem_Req_o,
  output logic        Mem_We_o,
  output logic [31:0] Mem_Addr_o,
  output logic [31:0] Mem_Wdata_o,
  output logic [3:0]  Mem_Wstrb_o,
  input  logic        Mem_Ack_i,
  input  logic [31:0] Mem_Rdata_i
);

  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  lsu_state_t  state;
  logic        cap_we;
  logic [2:0]  cap_f3;
  logic [1:0]  cap_lo;
  logic [15:0] wait_cnt;
  logic        bad_access;
  logic [2:0]  al_f3;
  logic [1:0]  al_lo;
  logic [31:0] al_wdata;
  logic [31:0] al_load;
  logic [3:0]  al_wstrb;

  // One aligner serves both directions: live inputs while idle (store lanes
  // are registered at accept), captured fields while waiting for the load word.
  assign al_f3 = (state == ST_IDLE) ? Funct3_i : cap_f3;
  assign al_lo = (state == ST_IDLE) ? Address_i[1:0] : cap_lo;

  lsu_align u_align (
    .funct3     (al_f3),
    .addr_lo    (al_lo),
    .store_data (Store_Data_i),
    .load_word  (Mem_Rdata_i),
    .wdata      (al_wdata),
    .wstrb      (al_wstrb),
    .load_data  (al_load)
  );

  always_comb begin
    case (Funct3_i)
      F3_B, F3_H, F3_W: bad_access = 1'b0;
      F3_BU, F3_HU:     bad_access = Mem_Write_i;
      default:          bad_access = 1'b1;
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    if ((Funct3_i == F3_H || Funct3_i == F3_HU) && Address_i[0])
      bad_access = 1'b1;
    if (Funct3_i == F3_W && Address_i[1:0] != 2'b00)
      bad_access = 1'b1;
`endif
  end

  assign Req_Ready_o = (state == ST_IDLE);
  assign Stall_o     = (state == ST_REQ) || (state == ST_IDLE && Req_Valid_i);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      Mem_Req_o   <= 1'b0;
      Mem_We_o    <= 1'b0;
      Done_o      <= 1'b0;
      Error_o     <= 1'b0;
      Mem_Wstrb_o <= '0;
      Mem_Addr_o  <= '0;
      Mem_Wdata_o <= '0;
      Load_Data_o <= '0;
      wait_cnt    <= '0;
      cap_we      <= 1'b0;
      cap_f3      <= '0;
      cap_lo      <= '0;
    end else begin
      Done_o  <= 1'b0;
      Error_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (Req_Valid_i) begin
            cap_we <= Mem_Write_i;
            cap_f3 <= Funct3_i;
            cap_lo <= Address_i[1:0];
            if (bad_access) begin
              state   <= ST_DONE;
              Done_o  <= 1'b1;
              Error_o <= 1'b1;
            end else begin
              state       <= ST_REQ;
              Mem_Req_o   <= 1'b1;
              Mem_We_o    <= Mem_Write_i;
              Mem_Addr_o  <= {Address_i[31:2], 2'b00};
              Mem_Wdata_o <= al_wdata;
              Mem_Wstrb_o <= Mem_Write_i ? al_wstrb : 4'b0000;
              wait_cnt    <= '0;
            end
          end
        end
        ST_REQ: begin
          if (Mem_Ack_i) begin
            state       <= ST_DONE;
            Done_o      <= 1'b1;
            Mem_Req_o   <= 1'b0;
            Mem_We_o    <= 1'b0;
            Mem_Wstrb_o <= '0;
            if (!cap_we)
              Load_Data_o <= al_load;
          end else if (wait_cnt == WAIT_LAST) begin
            state       <= ST_DONE;
            Done_o      <= 1'b1;
            Error_o     <= 1'b1;
            Mem_Req_o   <= 1'b0;
            Mem_We_o    <= 1'b0;
            Mem_Wstrb_o <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
